pa_clic_int_recv: RTL and testbench
===================================

// Module: pa_clic_int_recv
// PURPOSE
//  Core-side receiver of the CLIC interrupt request (req/id/il/mode/hv) driven by the CLIC ctrl stage.
//  Qualifies the request against the CSR state and presents it to the IU pipeline.
//  On take: returns a one-cycle ack (with ID) to the CLIC and, for hardware-vectored IDs, fetches the
//  vector-table entry over a simple read port.
// PARAMETERS
//  ID_WIDTH  12  interrupt ID width
//  ACK_LAT    2  cycles after ack before a new request is sampled (CLIC pending-clear latency), >=1
// PORTS
//  forever_cpuclk     in   1   clock
//  cpurst             in   1   reset, asynchronous, active-high
//  clic_cpu_int_req   in   1   CLIC request, level, held while pending
//  clic_cpu_int_id    in   12  winning ID
//  clic_cpu_int_il    in   8   interrupt level
//  clic_cpu_int_mode  in   1   1 = machine mode; only machine mode is taken
//  clic_cpu_int_hv    in   1   hardware-vectored
//  cp0_mie            in   1   mstatus.MIE
//  cp0_mil            in   8   mintstatus.MIL (current level)
//  cp0_mintthresh     in   8   mintthresh
//  cp0_mtvt           in   32  vector table base
//  recv_iu_int_vld    out  1   qualified interrupt pending toward IU
//  recv_iu_int_id     out  12  ID of pending interrupt, stable while vld=1
//  recv_iu_int_il     out  8   level of pending interrupt
//  recv_iu_int_hv     out  1   vectored flag of pending interrupt
//  iu_recv_int_take   in   1   IU accepts pending interrupt (valid only while vld=1)
//  recv_clic_int_ack  out  1   one-cycle ack pulse to CLIC
//  recv_clic_ack_id   out  12  ID being acked
//  recv_bus_req       out  1   vector fetch request, held until grant
//  recv_bus_addr      out  32  vector entry address
//  bus_recv_gnt       in   1   request accepted
//  bus_recv_rsp_vld   in   1   read data valid
//  bus_recv_rsp_data  in   32  read data
//  bus_recv_rsp_err   in   1   bus error with rsp_vld
//  recv_iu_pc_vld     out  1   one-cycle pulse: vector target ready
//  recv_iu_pc         out  32  target PC = rsp_data & ~32'h1
//  recv_iu_pc_err     out  1   with pc_vld: fetch faulted
//  recv_busy          out  1   FSM not IDLE/PEND (clock-gate enable)
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; latched id/il/hv=0; ack-wait counter=0.
//  qual = req & mode & mie & (il > mil) & (il > mintthresh) (unsigned 8-bit compares).
//  IDLE:     qual -> latch id/il/hv, go PEND (vld rises next cycle, 1-cycle latency).
//  PEND:     vld=1. take -> ACK. Else !qual -> IDLE (vld drops next cycle).
//            Else id differs from latched -> IDLE (vld drops 1 cycle, re-latches next).
//            take and withdraw/id change in the same cycle: take wins, latched values are used.
//  ACK:      ack=1 for exactly one cycle with ack_id=latched id; load counter=ACK_LAT;
//            hv ? VEC_REQ : WAIT.
//  VEC_REQ:  bus_req=1, addr={mtvt[31:6],6'b0}+{id,2'b00} (32-bit, wrap ignored); gnt -> VEC_RSP.
//            mtvt is sampled at ACK.
//  VEC_RSP:  rsp_vld -> pc_vld pulse, pc=data&~1, pc_err=rsp_err; go WAIT.
//            rsp_vld in the gnt cycle is not legal (bus protocol: >=1 cycle).
//  WAIT:     counter decrements each cycle (saturating at 0), starts on the ACK cycle;
//            IDLE when counter==0 and not in a vector state. Prevents re-taking a stale edge request.
//  No abort after take: the vector fetch always completes. Async reset mid-fetch returns to IDLE;
//  outstanding bus rsp after reset is ignored (rsp_vld outside VEC_RSP has no effect).
//  take while vld=0 is ignored. busy=1 in ACK/VEC_REQ/VEC_RSP/WAIT.
// STRUCTURE
//  Shared package/header: FSM state encodings (3-bit), ID_WIDTH, vector entry size (4 B).
//  Single module; the qualifier (compares + mie/mode) may be a combinational sub-module
//  pa_clic_int_qual.
// TESTING
//  1 mie=1, mil=0, thresh=0, req id=5 il=8'h80 hv=0 -> vld at +1; take -> ack pulse id=5; no bus_req;
//    vld low >= ACK_LAT cycles.
//  2 il=8'h40, mil=8'h40 -> vld never rises; set mil=8'h3F -> vld at +1.
//  3 PEND id=5, CLIC switches id=9 -> vld low one cycle, then vld with id=9; take+switch same cycle
//    -> ack id=5.
//  4 hv=1 id=3, mtvt=32'h2000_0040 -> addr 32'h2000_004C; gnt after 3 cycles, rsp data 32'h1001
//    -> pc=32'h1000, pc_err=0.
//  5 hv fetch with rsp_err=1 -> pc_vld with pc_err=1, FSM returns to IDLE; req still high ->
//    re-pend after ACK_LAT.
//  6 assert cpurst during VEC_RSP -> all outputs 0 at once; late rsp_vld ignored; normal take afterwards.

Source files
------------

// File: rtl/pa_clic_int_recv_pkg.sv
// Shared definitions for the CLIC interrupt receiver: FSM encodings, ID width,
// vector-table geometry and the vector entry address helper.
package pa_clic_int_recv_pkg;

  localparam int PA_CLIC_ID_WIDTH = 12;

  localparam logic [31:0] VEC_ENTRY_BYTES = 32'd4;
  localparam logic [31:0] VEC_BASE_MASK   = 32'hFFFF_FFC0;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PEND    = 3'd1;
  localparam logic [2:0] ST_ACK     = 3'd2;
  localparam logic [2:0] ST_VEC_REQ = 3'd3;
  localparam logic [2:0] ST_VEC_RSP = 3'd4;
  localparam logic [2:0] ST_WAIT    = 3'd5;

  // Table base is 64-byte aligned; entries are one word each.
  function automatic logic [31:0] vec_entry_addr(input logic [31:0] base,
                                                 input logic [31:0] idx);
    vec_entry_addr = (base & VEC_BASE_MASK) + (idx * VEC_ENTRY_BYTES);
  endfunction

endpackage

// File: rtl/pa_clic_int_qual.sv
// Combinational qualifier: decides whether the CLIC request may interrupt
// the core given the current machine-mode interrupt state.
module pa_clic_int_qual (
  input  logic       req,
  input  logic       mode,
  input  logic       mie,
  input  logic [7:0] il,
  input  logic [7:0] mil,
  input  logic [7:0] thresh,
  output logic       qual
);

  assign qual = req & mode & mie & (il > mil) & (il > thresh);

endmodule

// File: rtl/pa_clic_int_recv.sv
// Core-side CLIC interrupt receiver: qualifies the request, hands it to the IU,
// acks the CLIC on take and fetches the vector entry for hardware-vectored IDs.
module pa_clic_int_recv
  import pa_clic_int_recv_pkg::*;
#(
  parameter int ID_WIDTH = PA_CLIC_ID_WIDTH,
  parameter int ACK_LAT  = 2
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst,
  input  logic                clic_cpu_int_req,
  input  logic [ID_WIDTH-1:0] clic_cpu_int_id,
  input  logic [7:0]          clic_cpu_int_il,
  input  logic                clic_cpu_int_mode,
  input  logic                clic_cpu_int_hv,
  input  logic                cp0_mie,
  input  logic [7:0]          cp0_mil,
  input  logic [7:0]          cp0_mintthresh,
  input  logic [31:0]         cp0_mtvt,
  output logic                recv_iu_int_vld,
  output logic [ID_WIDTH-1:0] recv_iu_int_id,
  output logic [7:0]          recv_iu_int_il,
  output logic                recv_iu_int_hv,
  input  logic                iu_recv_int_take,
  output logic                recv_clic_int_ack,
  output logic [ID_WIDTH-1:0] recv_clic_ack_id,
  output logic                recv_bus_req,
  output logic [31:0]         recv_bus_addr,
  input  logic                bus_recv_gnt,
  input  logic                bus_recv_rsp_vld,
  input  logic [31:0]         bus_recv_rsp_data,
  input  logic                bus_recv_rsp_err,
  output logic                recv_iu_pc_vld,
  output logic [31:0]         recv_iu_pc,
  output logic                recv_iu_pc_err,
  output logic                recv_busy
);

  localparam int CNT_W = (ACK_LAT > 1) ? $clog2(ACK_LAT) : 1;
  // The ACK cycle itself counts as the first cycle of the pending-clear wait.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACK_LAT - 1);

  logic [2:0]          state_q, state_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [7:0]          il_q, il_d;
  logic                hv_q, hv_d;
  logic [31:0]         addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pc_vld_q, pc_vld_d;
  logic [31:0]         pc_q, pc_d;
  logic                pc_err_q, pc_err_d;
  logic                qual_s;

  pa_clic_int_qual u_qual (
    .req    (clic_cpu_int_req),
    .mode   (clic_cpu_int_mode),
    .mie    (cp0_mie),
    .il     (clic_cpu_int_il),
    .mil    (cp0_mil),
    .thresh (cp0_mintthresh),
    .qual   (qual_s)
  );

  // Next-state and datapath for the receive / ack / vector-fetch sequence.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    il_d     = il_q;
    hv_d     = hv_q;
    addr_d   = addr_q;
    cnt_d    = (cnt_q == {CNT_W{1'b0}}) ? {CNT_W{1'b0}} : (cnt_q - {{(CNT_W-1){1'b0}}, 1'b1});
    pc_vld_d = 1'b0;
    pc_d     = pc_q;
    pc_err_d = pc_err_q;
    case (state_q)
      ST_IDLE: begin
        if (qual_s) begin
          id_d    = clic_cpu_int_id;
          il_d    = clic_cpu_int_il;
          hv_d    = clic_cpu_int_hv;
          state_d = ST_PEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PEND: begin
        // Take has priority over a withdrawn or switched request.
        if (iu_recv_int_take) begin
          state_d = ST_ACK;
        end else if (!qual_s || (clic_cpu_int_id != id_q)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PEND;
        end
      end
      ST_ACK: begin
        cnt_d  = CNT_LOAD;
        addr_d = vec_entry_addr(cp0_mtvt, {{(32-ID_WIDTH){1'b0}}, id_q});
        if (hv_q) begin
          state_d = ST_VEC_REQ;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_VEC_REQ: begin
        if (bus_recv_gnt) begin
          state_d = ST_VEC_RSP;
        end else begin
          state_d = ST_VEC_REQ;
        end
      end
      ST_VEC_RSP: begin
        if (bus_recv_rsp_vld) begin
          pc_vld_d = 1'b1;
          pc_d     = bus_recv_rsp_data & ~32'h0000_0001;
          pc_err_d = bus_recv_rsp_err;
          state_d  = ST_WAIT;
        end else begin
          state_d = ST_VEC_RSP;
        end
      end
      ST_WAIT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state_q  <= ST_IDLE;
      id_q     <= {ID_WIDTH{1'b0}};
      il_q     <= 8'h00;
      hv_q     <= 1'b0;
      addr_q   <= 32'h0000_0000;
      cnt_q    <= {CNT_W{1'b0}};
      pc_vld_q <= 1'b0;
      pc_q     <= 32'h0000_0000;
      pc_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      il_q     <= il_d;
      hv_q     <= hv_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      pc_vld_q <= pc_vld_d;
      pc_q     <= pc_d;
      pc_err_q <= pc_err_d;
    end
  end

  assign recv_iu_int_vld   = (state_q == ST_PEND);
  assign recv_iu_int_id    = id_q;
  assign recv_iu_int_il    = il_q;
  assign recv_iu_int_hv    = hv_q;
  assign recv_clic_int_ack = (state_q == ST_ACK);
  assign recv_clic_ack_id  = id_q;
  assign recv_bus_req      = (state_q == ST_VEC_REQ);
  assign recv_bus_addr     = addr_q;
  assign recv_iu_pc_vld    = pc_vld_q;
  assign recv_iu_pc        = pc_q;
  assign recv_iu_pc_err    = pc_err_q;
  assign recv_busy         = (state_q == ST_ACK) | (state_q == ST_VEC_REQ) |
                             (state_q == ST_VEC_RSP) | (state_q == ST_WAIT);

endmodule

// File: tb/tb_pa_clic_int_recv.sv
// Self-checking bench for pa_clic_int_recv: directed scenarios plus random
// traffic, checked every cycle against a timestamp-based behavioural model.
module tb_pa_clic_int_recv;

  localparam int ACK_LAT = 2;
  localparam int BIG     = 1 << 30;

  logic        clk = 1'b0;
  logic        cpurst;
  logic        req, mode, hv, mie, take, gnt, rsp_vld, rsp_err;
  logic [11:0] id;
  logic [7:0]  il, mil, thr;
  logic [31:0] mtvt, rsp_data;

  logic        d_vld, d_hv, d_ack, d_breq, d_pcv, d_pcerr, d_busy;
  logic [11:0] d_id, d_ackid;
  logic [7:0]  d_il;
  logic [31:0] d_addr, d_pc;

  int total = 0;
  int bad   = 0;

  // Behavioural model: pending request plus timestamps of the ack and of the
  // cycle from which the receiver may sample a new request again.
  int          cyc = 0;
  bit          m_pend, m_req, m_rsp, m_pcv, m_err, m_hv;
  logic [11:0] m_id;
  logic [7:0]  m_il;
  logic [31:0] m_addr, m_pc;
  int          m_ack_cyc, m_free;

  pa_clic_int_recv #(.ID_WIDTH(12), .ACK_LAT(ACK_LAT)) dut (
    .forever_cpuclk    (clk),
    .cpurst            (cpurst),
    .clic_cpu_int_req  (req),
    .clic_cpu_int_id   (id),
    .clic_cpu_int_il   (il),
    .clic_cpu_int_mode (mode),
    .clic_cpu_int_hv   (hv),
    .cp0_mie           (mie),
    .cp0_mil           (mil),
    .cp0_mintthresh    (thr),
    .cp0_mtvt          (mtvt),
    .recv_iu_int_vld   (d_vld),
    .recv_iu_int_id    (d_id),
    .recv_iu_int_il    (d_il),
    .recv_iu_int_hv    (d_hv),
    .iu_recv_int_take  (take),
    .recv_clic_int_ack (d_ack),
    .recv_clic_ack_id  (d_ackid),
    .recv_bus_req      (d_breq),
    .recv_bus_addr     (d_addr),
    .bus_recv_gnt      (gnt),
    .bus_recv_rsp_vld  (rsp_vld),
    .bus_recv_rsp_data (rsp_data),
    .bus_recv_rsp_err  (rsp_err),
    .recv_iu_pc_vld    (d_pcv),
    .recv_iu_pc        (d_pc),
    .recv_iu_pc_err    (d_pcerr),
    .recv_busy         (d_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int later(input int a, input int b);
    later = (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    m_pend = 1'b0; m_req = 1'b0; m_rsp = 1'b0; m_pcv = 1'b0;
    m_ack_cyc = -1; m_free = 0;
  endtask

  task automatic model_step();
    bit q;
    int c;
    c = cyc + 1;
    q = req && mode && mie && (il > mil) && (il > thr);
    m_pcv = 1'b0;
    if (m_pend) begin
      if (take) begin
        m_pend = 1'b0; m_ack_cyc = c; m_free = BIG;
      end else if (!q || id != m_id) begin
        m_pend = 1'b0;
      end
    end else if (cyc == m_ack_cyc) begin
      if (m_hv) begin
        m_req  = 1'b1;
        m_addr = (mtvt & 32'hFFFF_FFC0) + 32'(m_id) * 32'd4;
      end else begin
        m_free = later(m_ack_cyc + ACK_LAT, cyc + 1) + 1;
      end
    end else if (m_req) begin
      if (gnt) begin m_req = 1'b0; m_rsp = 1'b1; end
    end else if (m_rsp) begin
      if (rsp_vld) begin
        m_rsp = 1'b0; m_pcv = 1'b1;
        m_pc = rsp_data & 32'hFFFF_FFFE; m_err = rsp_err;
        m_free = later(m_ack_cyc + ACK_LAT, cyc + 1) + 1;
      end
    end else if (cyc >= m_free && q) begin
      m_pend = 1'b1; m_id = id; m_il = il; m_hv = hv;
    end
    cyc = c;
  endtask

  task automatic compare_all();
    check("vld", 32'(d_vld), 32'(m_pend));
    if (m_pend) begin
      check("int_id", 32'(d_id), 32'(m_id));
      check("int_il", 32'(d_il), 32'(m_il));
      check("int_hv", 32'(d_hv), 32'(m_hv));
    end
    check("ack", 32'(d_ack), 32'(cyc == m_ack_cyc));
    if (cyc == m_ack_cyc) check("ack_id", 32'(d_ackid), 32'(m_id));
    check("bus_req", 32'(d_breq), 32'(m_req));
    if (m_req) check("bus_addr", d_addr, m_addr);
    check("pc_vld", 32'(d_pcv), 32'(m_pcv));
    if (m_pcv) begin
      check("pc", d_pc, m_pc);
      check("pc_err", 32'(d_pcerr), 32'(m_err));
    end
    check("busy", 32'(d_busy), 32'(!m_pend && cyc < m_free));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!cpurst) model_step();
    @(negedge clk);
    if (!cpurst) compare_all();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vld"},    32'(d_vld),   32'd0);
    check({tag, "_busy"},   32'(d_busy),  32'd0);
    check({tag, "_ack"},    32'(d_ack),   32'd0);
    check({tag, "_breq"},   32'(d_breq),  32'd0);
    check({tag, "_pcv"},    32'(d_pcv),   32'd0);
    check({tag, "_id"},     32'(d_id),    32'd0);
    check({tag, "_addr"},   d_addr,       32'd0);
    check({tag, "_pc"},     d_pc,         32'd0);
  endtask

  initial begin
    cpurst = 1'b1;
    req = 1'b0; mode = 1'b1; hv = 1'b0; mie = 1'b1; take = 1'b0;
    gnt = 1'b0; rsp_vld = 1'b0; rsp_err = 1'b0;
    id = 12'd0; il = 8'h00; mil = 8'h00; thr = 8'h00;
    mtvt = 32'h0; rsp_data = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    cpurst = 1'b0;
    tick();

    // 1: plain interrupt, ack, pending-clear gap
    req = 1'b1; id = 12'd5; il = 8'h80; hv = 1'b0;
    tick(); check("t1_vld", 32'(d_vld), 32'd1); check("t1_id", 32'(d_id), 32'd5);
    take = 1'b1; tick(); take = 1'b0;
    check("t1_ack", 32'(d_ack), 32'd1); check("t1_ack_id", 32'(d_ackid), 32'd5);
    for (int k = 0; k < ACK_LAT; k++) begin
      tick(); check("t1_vld_gap", 32'(d_vld), 32'd0); check("t1_no_breq", 32'(d_breq), 32'd0);
    end
    req = 1'b0; repeat (3) tick();

    // 2: level compare is strict
    req = 1'b1; il = 8'h40; mil = 8'h40;
    repeat (3) begin tick(); check("t2_vld_low", 32'(d_vld), 32'd0); end
    mil = 8'h3F; tick(); check("t2_vld", 32'(d_vld), 32'd1);

    // 3: ID switch drops vld a cycle; take wins over a same-cycle switch
    id = 12'd9; tick(); check("t3_drop", 32'(d_vld), 32'd0);
    tick(); check("t3_vld", 32'(d_vld), 32'd1); check("t3_id", 32'(d_id), 32'd9);
    id = 12'd5; take = 1'b1; tick(); take = 1'b0;
    check("t3_ack", 32'(d_ack), 32'd1); check("t3_ack_id", 32'(d_ackid), 32'd9);
    req = 1'b0; mil = 8'h00; repeat (5) tick();

    // 4: vectored fetch
    req = 1'b1; hv = 1'b1; id = 12'd3; il = 8'h80; mtvt = 32'h2000_0040;
    tick(); take = 1'b1; tick(); take = 1'b0; req = 1'b0;
    tick(); check("t4_breq", 32'(d_breq), 32'd1); check("t4_addr", d_addr, 32'h2000_004C);
    tick(); tick(); gnt = 1'b1; tick(); gnt = 1'b0;
    check("t4_breq_off", 32'(d_breq), 32'd0);
    rsp_vld = 1'b1; rsp_data = 32'h0000_1001; tick(); rsp_vld = 1'b0;
    check("t4_pcv", 32'(d_pcv), 32'd1); check("t4_pc", d_pc, 32'h0000_1000);
    check("t4_err", 32'(d_pcerr), 32'd0);
    repeat (5) tick();

    // 5: faulted fetch, request still high re-pends after the wait
    req = 1'b1; id = 12'd7;
    tick(); take = 1'b1; tick(); take = 1'b0;
    tick(); gnt = 1'b1; tick(); gnt = 1'b0; tick();
    rsp_vld = 1'b1; rsp_err = 1'b1; rsp_data = 32'h0000_2223; tick();
    rsp_vld = 1'b0; rsp_err = 1'b0;
    check("t5_pcv", 32'(d_pcv), 32'd1); check("t5_err", 32'(d_pcerr), 32'd1);
    check("t5_pc", d_pc, 32'h0000_2222);
    tick(); check("t5_wait", 32'(d_vld), 32'd0);
    tick(); check("t5_repend", 32'(d_vld), 32'd1);
    req = 1'b0; repeat (4) tick();

    // 6: reset in the middle of a fetch
    req = 1'b1; id = 12'd2;
    tick(); take = 1'b1; tick(); take = 1'b0;
    tick(); gnt = 1'b1; tick(); gnt = 1'b0;
    cpurst = 1'b1; #1;
    check_all_zero("t6_rst");
    model_reset();
    rsp_vld = 1'b1; rsp_data = 32'h0000_5555;
    tick(); tick();
    cpurst = 1'b0;
    tick(); rsp_vld = 1'b0; hv = 1'b0;
    tick(); check("t6_vld", 32'(d_vld), 32'd1); check("t6_pc_quiet", 32'(d_pcv), 32'd0);
    take = 1'b1; tick(); take = 1'b0;
    check("t6_ack_id", 32'(d_ackid), 32'd2);
    req = 1'b0; repeat (4) tick();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 11) == 0) req = ~req;
      if ($urandom_range(0, 7) == 0) id = 12'($urandom_range(0, 2) * 4 + 3);
      if ($urandom_range(0, 9) == 0) il = 8'($urandom);
      if ($urandom_range(0, 29) == 0) mil = 8'($urandom_range(0, 64));
      if ($urandom_range(0, 29) == 0) thr = 8'($urandom_range(0, 64));
      if ($urandom_range(0, 5) == 0) hv = 1'($urandom);
      if ($urandom_range(0, 19) == 0) mtvt = $urandom;
      mode = ($urandom_range(0, 15) != 0);
      mie  = ($urandom_range(0, 15) != 0);
      take = ($urandom_range(0, 2) == 0);
      gnt  = ($urandom_range(0, 2) == 0);
      rsp_vld  = ($urandom_range(0, 2) == 0);
      rsp_err  = ($urandom_range(0, 3) == 0);
      rsp_data = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
